if_id_pipe_reg: RTL
===================

// Module: if_id_pipe_reg
// PURPOSE
//  IF/ID pipeline register between the fetch stage and the decode stage.
//  Captures PC, PCplus4 and Instruction from fetch on each rising clock edge.
//  Holds its contents under single-cycle and two-cycle stall requests, which
//  mirror the PC register's stall / stall_twice inputs.
//  Inserts a NOP bubble with valid=0 when a taken branch flushes the
//  wrong-path fetch.
// PARAMETERS
//  WIDTH          32            datapath width (equal to `WORD_LEN)
//  NOP_INSTR      32'h00000013  bubble encoding (addi x0,x0,0)
//  STALL2_CYCLES  2             edges held per stall_twice request (>=2)
// PORTS
//  clk            in   1      clock, rising edge
//  Reset          in   1      asynchronous, active-high reset
//  stall          in   1      hold this edge (load-use hazard)
//  stall_twice    in   1      start a STALL2_CYCLES-edge hold
//  flush          in   1      taken branch (BranchTK from execute); insert bubble
//  PC_in          in   WIDTH  fetch PC
//  PCplus4_in     in   WIDTH  fetch PC+4
//  Instr_in       in   WIDTH  fetched instruction
//  ID_PC          out  WIDTH  registered PC
//  ID_PCplus4     out  WIDTH  registered PC+4
//  ID_Instr       out  WIDTH  registered instruction
//  ID_Valid       out  1      1 = real instruction, 0 = bubble
//  hold_active    out  1      combinational: register is holding this cycle
// BEHAVIOUR
//  - Reset (async, active-high): ID_PC=0, ID_PCplus4=0, ID_Instr=NOP_INSTR,
//    ID_Valid=0, hold_cnt=0. These values are held while Reset=1.
//  - hold_cnt: internal down-counter, width clog2(STALL2_CYCLES).
//  - hold_active = stall | stall_twice | (hold_cnt!=0).
//  - Per rising edge, in priority order:
//    1. flush=1:
//       - ID_Instr=NOP_INSTR, ID_Valid=0, hold_cnt=0.
//       - ID_PC and ID_PCplus4 load their inputs (debug only).
//       - flush overrides every stall and cancels any pending hold.
//    2. hold_active=1:
//       - All outputs keep their values.
//       - If stall_twice=1 and hold_cnt=0: hold_cnt <= STALL2_CYCLES-1.
//       - Else if hold_cnt!=0: hold_cnt <= hold_cnt-1.
//       - stall_twice asserted while hold_cnt!=0 does not extend the hold.
//    3. Otherwise: load all three data inputs and set ID_Valid=1.
//  - Latency: one cycle from input to output when no hold is active.
//  - stall_twice pulsed for one cycle: holds on that edge and the next
//    STALL2_CYCLES-1 edges. With the default, that is 2 edges total.
//  - stall and stall_twice in the same cycle: treated as stall_twice.
//  - Reset mid-hold: the counter clears immediately. The first edge after
//    Reset falls loads the inputs normally unless a stall is asserted.
//  - No X is allowed on any output after reset, including when inputs are X
//    while a hold is active.
// TESTING
//  1. Assert Reset, then release it.
//     -> ID_Instr=32'h00000013, ID_Valid=0, ID_PC=0.
//     The first edge with PC_in=0x0 and Instr_in=0x00500093 gives
//     ID_PC=0x0 and ID_Valid=1.
//  2. Stream PC 0x0,0x4,0x8 with stall=1 on the edge carrying 0x8.
//     -> ID_PC shows 0x4 for 2 cycles, then 0x8. ID_Valid stays 1.
//  3. One-cycle stall_twice pulse while ID_PC=0x10.
//     -> ID_PC stays 0x10 for 3 cycles total (the pulse edge plus one more),
//     then loads. hold_active is high for exactly 2 cycles.
//  4. flush=1 on the edge after a stall_twice pulse.
//     -> ID_Instr=0x00000013, ID_Valid=0. The next edge loads PC_in normally.
//  5. flush=1 and stall=1 in the same cycle.
//     -> a bubble is inserted (flush wins) and hold_cnt=0.
//  6. Assert Reset asynchronously mid-cycle while hold_cnt=1.
//     -> outputs reach reset values before the next edge. After release,
//     the first edge loads.

Source files
------------

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: captures fetch-stage PC, PC+4 and instruction,
// holds under single- and multi-edge stalls, and turns a taken-branch flush
// into a NOP bubble with ID_Valid=0.
module if_id_pipe_reg #(
    parameter int               WIDTH         = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR     = 32'h00000013,
    parameter int               STALL2_CYCLES = 2
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             stall,
    input  logic             stall_twice,
    input  logic             flush,
    input  logic [WIDTH-1:0] PC_in,
    input  logic [WIDTH-1:0] PCplus4_in,
    input  logic [WIDTH-1:0] Instr_in,
    output logic [WIDTH-1:0] ID_PC,
    output logic [WIDTH-1:0] ID_PCplus4,
    output logic [WIDTH-1:0] ID_Instr,
    output logic             ID_Valid,
    output logic             hold_active
);

    // The counter only tracks the extra edges after the stall_twice edge
    // itself, so it needs to count down from STALL2_CYCLES-1.
    localparam int CNT_W = (STALL2_CYCLES > 1) ? $clog2(STALL2_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(STALL2_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [WIDTH-1:0] id_pc_q,      id_pc_d;
    logic [WIDTH-1:0] id_pcplus4_q, id_pcplus4_d;
    logic [WIDTH-1:0] id_instr_q,   id_instr_d;
    logic             id_valid_q,   id_valid_d;
    logic [CNT_W-1:0] hold_cnt_q,   hold_cnt_d;
    logic             hold_now;

    // Hold this edge on any stall request or while a multi-edge hold is pending.
    always_comb begin
        hold_now = stall | stall_twice | (hold_cnt_q != CNT_ZERO);
    end

    // Next-state selection: flush beats hold, hold beats a normal load.
    always_comb begin
        id_pc_d      = id_pc_q;
        id_pcplus4_d = id_pcplus4_q;
        id_instr_d   = id_instr_q;
        id_valid_d   = id_valid_q;
        hold_cnt_d   = hold_cnt_q;

        if (flush) begin
            // PC fields still load so the bubble carries a traceable address.
            id_pc_d      = PC_in;
            id_pcplus4_d = PCplus4_in;
            id_instr_d   = NOP_INSTR;
            id_valid_d   = 1'b0;
            hold_cnt_d   = CNT_ZERO;
        end else if (hold_now) begin
            // A stall_twice arriving during a pending hold must not restart it.
            if (stall_twice && (hold_cnt_q == CNT_ZERO)) begin
                hold_cnt_d = HOLD_RELOAD;
            end else if (hold_cnt_q != CNT_ZERO) begin
                hold_cnt_d = hold_cnt_q - CNT_ONE;
            end
        end else begin
            id_pc_d      = PC_in;
            id_pcplus4_d = PCplus4_in;
            id_instr_d   = Instr_in;
            id_valid_d   = 1'b1;
        end
    end

    // State registers with asynchronous reset to an empty (bubble) stage.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            id_pc_q      <= '0;
            id_pcplus4_q <= '0;
            id_instr_q   <= NOP_INSTR;
            id_valid_q   <= 1'b0;
            hold_cnt_q   <= CNT_ZERO;
        end else begin
            id_pc_q      <= id_pc_d;
            id_pcplus4_q <= id_pcplus4_d;
            id_instr_q   <= id_instr_d;
            id_valid_q   <= id_valid_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    // Drive outputs straight from the registers.
    always_comb begin
        ID_PC       = id_pc_q;
        ID_PCplus4  = id_pcplus4_q;
        ID_Instr    = id_instr_q;
        ID_Valid    = id_valid_q;
        hold_active = hold_now;
    end

endmodule
